// File: rtl/pc_sequencer_if.sv
// Fetch-side bundle between the PC sequencer (master) and the hazard/branch logic plus IF stage (slave).
interface pc_sequencer_if #(
  parameter int PC_WIDTH = 6
);
  logic                stall;
  logic                branch_taken;
  logic [PC_WIDTH-1:0] branch_target;
  logic                jump;
  logic [PC_WIDTH-1:0] jump_target;
  logic                halt;
  logic [PC_WIDTH-1:0] PC;
  logic                IF_Flush;
  logic                fetch_valid;
  logic [7:0]          redirect_count;

  modport master (
    input  stall, branch_taken, branch_target, jump, jump_target, halt,
    output PC, IF_Flush, fetch_valid, redirect_count
  );

  modport slave (
    output stall, branch_taken, branch_target, jump, jump_target, halt,
    input  PC, IF_Flush, fetch_valid, redirect_count
  );
endinterface

// File: rtl/pc_sequencer.sv
// Program counter sequencer: step, stall, branch/jump redirect with wrong-path squash, sticky halt.
// Optional build macro BRANCH_DELAY_SLOT_EN: the fetch at a redirect is a delay slot and is not squashed.
module pc_sequencer #(
  parameter int PC_WIDTH     = 6,
  parameter int RESET_PC     = 0,
  parameter int PC_STEP      = 4,
  parameter int FLUSH_CYCLES = 1
) (
  input  logic           clk,
  input  logic           reset,
  pc_sequencer_if.master io_fetch
);

  localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  typedef enum logic [1:0] {
    S_RUN    = 2'd0,
    S_FLUSH  = 2'd1,
    S_HALTED = 2'd2
  } state_e;

  state_e              r_state;
  logic [PC_WIDTH-1:0] r_pc;
  logic [CNT_W-1:0]    r_flush_cnt;
  logic [7:0]          r_redirect_count;

  state_e              w_state_nxt;
  logic [PC_WIDTH-1:0] w_pc_nxt;
  logic [CNT_W-1:0]    w_flush_cnt_nxt;
  logic [7:0]          w_redirect_count_nxt;

  logic                w_halted;
  logic                w_redirect;
  logic [PC_WIDTH-1:0] w_target_raw;
  logic [PC_WIDTH-1:0] w_target;
  logic                w_if_flush;

  assign w_halted     = (r_state == S_HALTED);
  assign w_redirect   = (io_fetch.branch_taken | io_fetch.jump) & ~w_halted;
  assign w_target_raw = io_fetch.branch_taken ? io_fetch.branch_target : io_fetch.jump_target;
  // Targets are word aligned regardless of what ID hands us.
  assign w_target     = {w_target_raw[PC_WIDTH-1:2], 2'b00};

  // NOTE: non-blocking assignments so every register samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state          <= S_RUN;
      r_pc             <= PC_WIDTH'(RESET_PC);
      r_flush_cnt      <= '0;
      r_redirect_count <= '0;
    end else begin
      r_state          <= w_state_nxt;
      r_pc             <= w_pc_nxt;
      r_flush_cnt      <= w_flush_cnt_nxt;
      r_redirect_count <= w_redirect_count_nxt;
    end
  end

`ifndef BRANCH_DELAY_SLOT_EN
  localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(FLUSH_CYCLES - 1);
`endif

  // NOTE: every signal gets a default first so no path through this block can infer a latch.
  always_comb begin
    w_state_nxt          = r_state;
    w_pc_nxt             = r_pc;
    w_flush_cnt_nxt      = (r_flush_cnt != '0) ? r_flush_cnt - 1'b1 : r_flush_cnt;
    w_redirect_count_nxt = r_redirect_count;

    if (w_halted) begin
      w_flush_cnt_nxt = r_flush_cnt;
    end else if (io_fetch.halt) begin
      w_state_nxt = S_HALTED;
    end else if (w_redirect) begin
      // Redirect overrides stall: a held wrong-path PC would refetch squashed code.
      w_pc_nxt = w_target;
      if (r_redirect_count != 8'hFF) begin
        w_redirect_count_nxt = r_redirect_count + 8'd1;
      end
`ifndef BRANCH_DELAY_SLOT_EN
      w_flush_cnt_nxt = FLUSH_LOAD;
      w_state_nxt     = (FLUSH_CYCLES > 1) ? S_FLUSH : S_RUN;
`endif
    end else begin
      if (!io_fetch.stall) begin
        w_pc_nxt = r_pc + PC_WIDTH'(PC_STEP);
      end
      if (r_state == S_FLUSH && w_flush_cnt_nxt == '0) begin
        w_state_nxt = S_RUN;
      end
    end
  end

`ifdef BRANCH_DELAY_SLOT_EN
  assign w_if_flush = reset | w_halted;
`else
  assign w_if_flush = reset | w_halted | w_redirect | (r_flush_cnt != '0);
`endif

  assign io_fetch.PC             = r_pc;
  assign io_fetch.IF_Flush       = w_if_flush;
  assign io_fetch.fetch_valid    = ~w_if_flush & ~io_fetch.stall & ~w_halted;
  assign io_fetch.redirect_count = r_redirect_count;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios, counter saturation, then random traffic vs a reference model.
module tb_pc_sequencer;

  localparam int PC_W = 6;
  localparam int FC   = 3;

  logic clk = 1'b0;
  logic reset;

  pc_sequencer_if #(.PC_WIDTH(PC_W)) bus_if ();

  pc_sequencer #(
    .PC_WIDTH    (PC_W),
    .RESET_PC    (0),
    .PC_STEP     (4),
    .FLUSH_CYCLES(FC)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .io_fetch(bus_if)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: architectural view only.
  int m_pc         = 0;
  bit m_halted     = 1'b0;
  int m_flush_left = 0;
  int m_count      = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive on the falling edge, check combinational/registered outputs, then advance the model.
  task automatic step(input bit rst, input bit st, input bit bt, input int btg,
                      input bit jp, input int jtg, input bit hlt);
    bit redir;
    int tgt;
    bit exp_flush;
    @(negedge clk);
    reset                = rst;
    bus_if.stall         = st;
    bus_if.branch_taken  = bt;
    bus_if.branch_target = PC_W'(btg);
    bus_if.jump          = jp;
    bus_if.jump_target   = PC_W'(jtg);
    bus_if.halt          = hlt;
    #1;
    redir = (bt || jp) && !m_halted;
    tgt   = (bt ? btg : jtg) & 32'h3C;
`ifdef BRANCH_DELAY_SLOT_EN
    exp_flush = rst || m_halted;
`else
    exp_flush = rst || m_halted || redir || (m_flush_left > 0);
`endif
    check("if_flush", 32'(bus_if.IF_Flush), 32'(exp_flush));
    if (!rst) begin
      check("pc", 32'(bus_if.PC), 32'(m_pc));
      check("fetch_valid", 32'(bus_if.fetch_valid), 32'(!exp_flush && !st && !m_halted));
      check("redirect_count", 32'(bus_if.redirect_count), 32'(m_count));
    end
    @(posedge clk);
    if (rst) begin
      m_pc = 0; m_halted = 1'b0; m_flush_left = 0; m_count = 0;
    end else if (m_halted) begin
      // frozen until reset
    end else if (hlt) begin
      m_halted = 1'b1;
    end else if (redir) begin
      m_pc    = tgt;
      m_count = (m_count < 255) ? m_count + 1 : 255;
`ifndef BRANCH_DELAY_SLOT_EN
      m_flush_left = FC - 1;
`endif
    end else begin
      if (!st) m_pc = (m_pc + 4) % 64;
      if (m_flush_left > 0) m_flush_left--;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    reset                = 1'b1;
    bus_if.stall         = 1'b0;
    bus_if.branch_taken  = 1'b0;
    bus_if.branch_target = '0;
    bus_if.jump          = 1'b0;
    bus_if.jump_target   = '0;
    bus_if.halt          = 1'b0;

    // Reset for two clocks, then release.
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    #1 check("pc_after_reset", 32'(bus_if.PC), 32'h00);

    // Free run through the wrap at 0x3C -> 0x00.
    idle(16);
    #1 check("pc_wrap", 32'(bus_if.PC), 32'h00);
    idle(2);
    #1 check("pc_before_stall", 32'(bus_if.PC), 32'h08);

    // Stall three clocks, then release.
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0, 0, 0);
    #1 check("pc_stalled", 32'(bus_if.PC), 32'h08);
    idle(1);
    #1 check("pc_after_stall", 32'(bus_if.PC), 32'h0C);
    idle(1);

    // Taken branch to 0x23 during a stall: redirect wins, target aligned.
    step(0, 1, 1, 'h23, 0, 0, 0);
    #1 check("pc_branch", 32'(bus_if.PC), 32'h20);
    check("count_branch", 32'(bus_if.redirect_count), 32'd1);
    idle(3);

    // Branch and jump together: branch wins.
    step(0, 0, 1, 'h30, 1, 'h04, 0);
    #1 check("pc_branch_over_jump", 32'(bus_if.PC), 32'h30);
    // New redirect mid-flush restarts the flush window.
    idle(1);
    step(0, 0, 0, 0, 1, 'h14, 0);
    #1 check("pc_jump_in_flush", 32'(bus_if.PC), 32'h14);
    idle(3);

    // Halt with a simultaneous branch: halt wins, PC and count frozen.
    step(0, 0, 1, 'h08, 0, 0, 1);
    #1 check("pc_halted", 32'(bus_if.PC), 32'h20);
    check("count_halted", 32'(bus_if.redirect_count), 32'd3);
    step(0, 0, 1, 'h2C, 0, 0, 0);
    step(0, 1, 0, 0, 1, 'h10, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    #1 check("pc_still_halted", 32'(bus_if.PC), 32'h20);

    // Reset out of HALTED.
    step(1, 0, 0, 0, 0, 0, 0);
    #1 check("pc_reset_from_halt", 32'(bus_if.PC), 32'h00);
    check("count_reset_from_halt", 32'(bus_if.redirect_count), 32'd0);

    // Saturate the redirect counter.
    for (int i = 0; i < 260; i++) step(0, 0, 0, 0, 1, $urandom_range(63), 0);
    #1 check("count_saturated", 32'(bus_if.redirect_count), 32'd255);
    idle(3);

    // Reset mid-flush, then random traffic.
    step(0, 0, 1, $urandom_range(63), 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 500; i++) begin
      step($urandom_range(49) == 0,
           $urandom_range(3) == 0,
           $urandom_range(5) == 0, $urandom_range(63),
           $urandom_range(5) == 0, $urandom_range(63),
           $urandom_range(39) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
